// File: rtl/music_pkg.sv
// Shared types and 25 MHz note divider constants for the musicbox design.
package music_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam int unsigned CLK_HZ = 25_000_000;

  // Half-period divider for a tone: the counter runs 0..div, so subtract one.
  function automatic int unsigned half_period_div(input int unsigned freq_hz);
    return CLK_HZ / (2 * freq_hz) - 1;
  endfunction

  localparam int unsigned NOTE_REST = 0;
  localparam int unsigned NOTE_A4   = half_period_div(440);
  localparam int unsigned NOTE_B4   = half_period_div(494);
  localparam int unsigned NOTE_C5   = half_period_div(523);
  localparam int unsigned NOTE_D5   = half_period_div(587);
  localparam int unsigned NOTE_E5   = half_period_div(659);

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles sq every div+1 cycles; div=0 holds sq low (rest).
module tone_divider #(
  parameter int DIV_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sq
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_sq;

  always_ff @(posedge clk) begin
    if (reset || clear || (div == '0)) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (r_cnt == div) begin
      r_cnt <= '0;
      r_sq  <= ~r_sq;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sq = r_sq;

endmodule

// File: rtl/tone_sequencer.sv
// Programmable melody player: steps through a note table, driving the
// speaker via tone_divider, with optional looping and start/stop control.
//
// state | meaning
// IDLE  | silent, counters held at 0, waiting for start
// PLAY  | playing table[note_idx], advancing on each note end
module tone_sequencer
  import music_pkg::*;
#(
  parameter int DIV_WIDTH = 15,
  parameter int DUR_WIDTH = 24,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DIV_WIDTH-1:0] wr_div,
  input  logic [DUR_WIDTH-1:0] wr_dur,
  input  logic [ADDR_W-1:0]    last_idx,
  input  logic                 loop,
  input  logic                 start,
  input  logic                 stop,
  output logic                 speaker,
  output logic                 busy,
  output logic [ADDR_W-1:0]    note_idx,
  output logic                 done
);

  logic [DIV_WIDTH-1:0] r_tbl_div [DEPTH];
  logic [DUR_WIDTH-1:0] r_tbl_dur [DEPTH];

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_W-1:0]    r_idx;
  logic [ADDR_W-1:0]    w_next_idx;
  logic [DIV_WIDTH-1:0] r_cur_div;
  logic [DUR_WIDTH-1:0] r_cur_dur;
  logic [DUR_WIDTH-1:0] r_dur_cnt;
  logic                 r_done;

  logic w_note_end;
  logic w_load;
  logic w_clear;
  logic w_done_set;

  // Loads read the table combinationally before the edge, so a same-cycle
  // write to the loaded index is seen only on its next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_div[i] <= '0;
        r_tbl_dur[i] <= '0;
      end
    end else if (wr_en) begin
      r_tbl_div[wr_addr] <= wr_div;
      r_tbl_dur[wr_addr] <= wr_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_load       = 1'b0;
    w_clear      = 1'b1;
    w_done_set   = 1'b0;
    w_note_end   = (r_state == ST_PLAY) && (r_dur_cnt == r_cur_dur);

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_next_state = ST_PLAY;
          w_next_idx   = '0;
          w_load       = 1'b1;
        end
      end
      ST_PLAY: begin
        w_clear = 1'b0;
        if (stop) begin
          w_next_state = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_note_end) begin
          // Every note boundary restarts tone phase and duration from zero.
          w_clear = 1'b1;
          if (r_idx != last_idx) begin
            w_next_idx = r_idx + 1'b1;
            w_load     = 1'b1;
          end else if (loop) begin
            w_next_idx = '0;
            w_load     = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
            w_done_set   = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_cur_div <= '0;
      r_cur_dur <= '0;
      r_dur_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_idx  <= w_next_idx;
      r_done <= w_done_set;
      if (w_load) begin
        r_cur_div <= r_tbl_div[w_next_idx];
        r_cur_dur <= r_tbl_dur[w_next_idx];
      end
      if (w_clear) begin
        r_dur_cnt <= '0;
      end else begin
        r_dur_cnt <= r_dur_cnt + 1'b1;
      end
    end
  end

  tone_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tone_divider (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .div   (r_cur_div),
    .sq    (speaker)
  );

  assign busy     = (r_state == ST_PLAY);
  assign note_idx = r_idx;
  assign done     = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer against a behavioural melody model.
module tb_tone_sequencer;

  localparam int DW    = 15;
  localparam int UW    = 24;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_div;
  logic [UW-1:0] wr_dur;
  logic [AW-1:0] last_idx;
  logic          loop;
  logic          start;
  logic          stop;
  logic          speaker;
  logic          busy;
  logic [AW-1:0] note_idx;
  logic          done;

  int n_cmp;
  int n_bad;

  // Model: which note is playing and how many cycles into it we are.
  int m_tbl_div [DEPTH];
  int m_tbl_dur [DEPTH];
  bit m_play;
  bit m_done;
  int m_idx;
  int m_el;
  int m_div;
  int m_dur;

  tone_sequencer #(
    .DIV_WIDTH(DW),
    .DUR_WIDTH(UW),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_div   (wr_div),
    .wr_dur   (wr_dur),
    .last_idx (last_idx),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .speaker  (speaker),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square wave of half-period div+1 starting low at the note's first cycle.
  function automatic bit exp_spk();
    if (!m_play || m_div == 0) return 1'b0;
    return ((m_el / (m_div + 1)) % 2) == 1;
  endfunction

  task automatic model_edge();
    bit ld;
    int nidx;
    ld     = 1'b0;
    nidx   = 0;
    m_done = 1'b0;
    if (reset) begin
      m_play = 1'b0;
      m_idx  = 0;
      m_el   = 0;
      m_div  = 0;
      m_dur  = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_tbl_div[i] = 0;
        m_tbl_dur[i] = 0;
      end
      return;
    end
    if (!m_play) begin
      if (start && !stop) begin
        ld     = 1'b1;
        nidx   = 0;
        m_play = 1'b1;
      end
    end else if (stop) begin
      m_play = 1'b0;
      m_el   = 0;
    end else if (m_el == m_dur) begin
      if (m_idx != int'(last_idx)) begin
        ld   = 1'b1;
        nidx = (m_idx + 1) % DEPTH;
      end else if (loop) begin
        ld   = 1'b1;
        nidx = 0;
      end else begin
        m_play = 1'b0;
        m_done = 1'b1;
        m_el   = 0;
      end
    end else begin
      m_el++;
    end
    if (ld) begin
      m_idx = nidx;
      m_div = m_tbl_div[nidx];
      m_dur = m_tbl_dur[nidx];
      m_el  = 0;
    end
    if (wr_en) begin
      m_tbl_div[wr_addr] = int'(wr_div);
      m_tbl_dur[wr_addr] = int'(wr_dur);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d, input int u);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_div  = DW'(d);
    wr_dur  = UW'(u);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go_idle();
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({speaker, busy, done, note_idx} !== {1'b0, 1'b0, 1'b0, AW'(0)}) begin
      n_bad++;
      $display("FAIL reset_state got spk/busy/done/idx=%b/%b/%b/%0d want 0/0/0/0",
               speaker, busy, done, note_idx);
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      n_cmp++;
      if ({speaker, busy, done} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_quiet cyc=%0d got spk/busy/done=%b/%b/%b want 0/0/0",
                 k, speaker, busy, done);
      end
    end
  endtask

  task automatic test_single_loop();
    write_entry(0, 3, 19);
    last_idx = AW'(0);
    loop     = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      n_cmp++;
      if ({speaker, busy, done, note_idx} !== {exp_spk(), m_play, m_done, AW'(m_idx)}) begin
        n_bad++;
        $display("FAIL single_loop cyc=%0d got spk/busy/done/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, speaker, busy, done, note_idx, exp_spk(), m_play, m_done, m_idx);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_melody();
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = -1;
    write_entry(0, 2, 9);
    write_entry(1, 0, 4);
    write_entry(2, 1, 7);
    last_idx = AW'(2);
    loop     = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      n_cmp++;
      if ({speaker, busy, done, note_idx} !== {exp_spk(), m_play, m_done, AW'(m_idx)}) begin
        n_bad++;
        $display("FAIL melody cyc=%0d got spk/busy/done/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, speaker, busy, done, note_idx, exp_spk(), m_play, m_done, m_idx);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      tick();
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != 24) begin
      n_bad++;
      $display("FAIL melody_done got count=%0d cycle=%0d want count=1 cycle=24", done_cnt, done_cyc);
    end
  endtask

  task automatic test_abort();
    write_entry(0, 1, 30);
    last_idx = AW'(0);
    loop     = 1'b0;
    start    = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if ({busy, speaker, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_stop got busy/spk/done=%b/%b/%b want 0/0/0", busy, speaker, done);
    end
    tick();
    n_cmp++;
    if ({busy, speaker, done, note_idx} !== {1'b1, exp_spk(), 1'b0, AW'(0)}) begin
      n_bad++;
      $display("FAIL abort_restart got busy/spk/done/idx=%b/%b/%b/%0d want 1/%b/0/0",
               busy, speaker, done, note_idx, exp_spk());
    end
    go_idle();
  endtask

  task automatic test_priority();
    write_entry(0, 2, 9);
    write_entry(1, 0, 4);
    write_entry(2, 1, 7);
    last_idx = AW'(2);
    loop     = 1'b1;
    start    = 1'b1;
    stop     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL prio_idle cyc=%0d got busy=%b want 0", k, busy);
      end
    end
    stop = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      start = (k >= 12 && k < 16);
      n_cmp++;
      if ({speaker, busy, done, note_idx} !== {exp_spk(), m_play, m_done, AW'(m_idx)}) begin
        n_bad++;
        $display("FAIL prio_play cyc=%0d got spk/busy/done/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, speaker, busy, done, note_idx, exp_spk(), m_play, m_done, m_idx);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_write_during_play();
    int guard;
    write_entry(0, 1, 5);
    write_entry(1, 2, 9);
    last_idx = AW'(1);
    loop     = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (note_idx !== AW'(1) && guard < 50) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 50) begin
      n_bad++;
      $display("FAIL wdp_reach_idx1 got note_idx=%0d want 1 within 50 cycles", note_idx);
    end
    tick();
    tick();
    wr_en   = 1'b1;
    wr_addr = AW'(1);
    wr_div  = DW'(5);
    wr_dur  = UW'(9);
    for (int k = 0; k < 60; k++) begin
      n_cmp++;
      if ({speaker, busy, done, note_idx} !== {exp_spk(), m_play, m_done, AW'(m_idx)}) begin
        n_bad++;
        $display("FAIL wdp cyc=%0d got spk/busy/done/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, speaker, busy, done, note_idx, exp_spk(), m_play, m_done, m_idx);
      end
      tick();
      wr_en = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({speaker, busy, done, note_idx} !== {1'b0, 1'b0, 1'b0, AW'(0)}) begin
      n_bad++;
      $display("FAIL midplay_reset got spk/busy/done/idx=%b/%b/%b/%0d want 0/0/0/0",
               speaker, busy, done, note_idx);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom_range(5, 0), $urandom_range(15, 0));
    last_idx = AW'($urandom_range(DEPTH - 1, 0));
    loop     = 1'($urandom_range(1, 0));
    for (int k = 0; k < 3000; k++) begin
      wr_en   = ($urandom_range(7, 0) == 0);
      wr_addr = AW'($urandom_range(DEPTH - 1, 0));
      wr_div  = DW'($urandom_range(5, 0));
      wr_dur  = UW'($urandom_range(15, 0));
      if ($urandom_range(63, 0) == 0) last_idx = AW'($urandom_range(DEPTH - 1, 0));
      if ($urandom_range(63, 0) == 0) loop = ~loop;
      start = ($urandom_range(3, 0) == 0);
      stop  = ($urandom_range(49, 0) == 0);
      tick();
      n_cmp++;
      if ({speaker, busy, done, note_idx} !== {exp_spk(), m_play, m_done, AW'(m_idx)}) begin
        n_bad++;
        $display("FAIL random cyc=%0d got spk/busy/done/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, speaker, busy, done, note_idx, exp_spk(), m_play, m_done, m_idx);
      end
    end
    wr_en = 1'b0;
    go_idle();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_div   = '0;
    wr_dur   = '0;
    last_idx = '0;
    loop     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    m_play   = 1'b0;
    m_done   = 1'b0;
    m_idx    = 0;
    m_el     = 0;
    m_div    = 0;
    m_dur    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_tbl_div[i] = 0;
      m_tbl_dur[i] = 0;
    end
    test_reset();
    test_single_loop();
    test_melody();
    test_abort();
    test_priority();
    test_write_during_play();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
